// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the CORDIC sine core: streams the ROM coefficient LUT into the core, pulses its reset, then forwards nsamples amplitudes.
// Latency: first LUT write 2 cycles after start; sample out 1 cycle after cor_wen_out; done coincides with the last sample.
// No backpressure: samples follow cor_wen_out. Define CORDIC_SEQ_ABORT_EN to add an abort input that ends LOAD/FLUSH/RUN early.
module cordic_seq_ctrl #(
    parameter int IDX_W   = 6,
    parameter int DW      = 48,
    parameter int AMP_W   = 16,
    parameter int RST_CYC = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMP_W-1:0] fcw_in,
    input  logic [AMP_W-1:0] offset_in,
    input  logic [CNT_W-1:0] nsamples,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [DW-1:0]    rom_data,
    output logic             cor_reset,
    output logic             cor_cen,
    output logic             cor_wen,
    output logic [IDX_W-1:0] cor_index,
    output logic [DW-1:0]    cor_d,
    output logic [AMP_W-1:0] cor_fcw,
    output logic [AMP_W-1:0] cor_offset,
    input  logic             cor_wen_out,
    input  logic [AMP_W-1:0] cor_amp,
`ifdef CORDIC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             smp_valid,
    output logic [AMP_W-1:0] smp_data,
    output logic             busy,
    output logic             done
);

    localparam int LUT_N = 2**IDX_W;
    localparam int LD_W  = IDX_W + 1;
    localparam int FL_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [LD_W-1:0] LD_ONE  = LD_W'(1);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(LUT_N);
    localparam logic [LD_W-1:0] LD_END  = LD_W'(LUT_N + 1);
    localparam logic [FL_W-1:0] FL_END  = FL_W'(RST_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DONE} state_t;

    state_t           state, state_n;
    logic [LD_W-1:0]  ld_cnt, ld_cnt_n;
    logic [FL_W-1:0]  fl_cnt, fl_cnt_n;
    logic [CNT_W-1:0] smp_cnt, smp_cnt_n, smp_inc;
    logic [CNT_W-1:0] nsmp_q, nsmp_q_n;
    logic [AMP_W-1:0] fcw_q, fcw_q_n, off_q, off_q_n;
    logic [IDX_W-1:0] rom_addr_n, cor_index_n;
    logic [DW-1:0]    cor_d_n;
    logic [AMP_W-1:0] cor_fcw_n, cor_offset_n, smp_data_n;
    logic             cor_reset_n, cor_cen_n, cor_wen_n, smp_valid_n, busy_n, done_n;
    logic             abort_hit;

`ifdef CORDIC_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign smp_inc = smp_cnt + CNT_W'(1);

    always_comb begin
        state_n      = state;
        ld_cnt_n     = ld_cnt;
        fl_cnt_n     = fl_cnt;
        smp_cnt_n    = smp_cnt;
        nsmp_q_n     = nsmp_q;
        fcw_q_n      = fcw_q;
        off_q_n      = off_q;
        rom_addr_n   = rom_addr;
        cor_index_n  = cor_index;
        cor_d_n      = cor_d;
        cor_fcw_n    = cor_fcw;
        cor_offset_n = cor_offset;
        smp_data_n   = smp_data;
        cor_reset_n  = cor_reset;
        cor_cen_n    = cor_cen;
        cor_wen_n    = cor_wen;
        busy_n       = busy;
        smp_valid_n  = 1'b0;
        done_n       = 1'b0;

        case (state)
            S_IDLE: begin
                cor_cen_n = 1'b1;
                cor_wen_n = 1'b1;
                if (start) begin
                    state_n     = S_LOAD;
                    fcw_q_n     = fcw_in;
                    off_q_n     = offset_in;
                    nsmp_q_n    = nsamples;
                    ld_cnt_n    = '0;
                    fl_cnt_n    = '0;
                    smp_cnt_n   = '0;
                    rom_addr_n  = '0;
                    cor_reset_n = 1'b1;
                    cor_cen_n   = 1'b0;
                    busy_n      = 1'b1;
                end
            end
            S_LOAD: begin
                // ROM data lags the address by one cycle, so write k lands when ld_cnt == k+1
                ld_cnt_n = ld_cnt + LD_ONE;
                if (rom_addr != '1) rom_addr_n = rom_addr + IDX_W'(1);
                if (ld_cnt >= LD_ONE && ld_cnt <= LD_LAST) begin
                    cor_wen_n   = 1'b0;
                    cor_index_n = ld_cnt[IDX_W-1:0] - IDX_W'(1);
                    cor_d_n     = rom_data;
                end
                if (ld_cnt == LD_END) begin
                    cor_wen_n    = 1'b1;
                    cor_reset_n  = 1'b0;
                    cor_fcw_n    = fcw_q;
                    cor_offset_n = off_q;
                    fl_cnt_n     = '0;
                    state_n      = S_FLUSH;
                end
            end
            S_FLUSH: begin
                cor_wen_n = 1'b1;
                if (fl_cnt == FL_END) begin
                    cor_reset_n = 1'b1;
                    if (nsmp_q == '0) begin
                        state_n   = S_DONE;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        cor_cen_n = 1'b1;
                    end else begin
                        state_n = S_RUN;
                    end
                end else begin
                    fl_cnt_n = fl_cnt + FL_W'(1);
                end
            end
            S_RUN: begin
                if (cor_wen_out) begin
                    smp_valid_n = 1'b1;
                    smp_data_n  = cor_amp;
                    smp_cnt_n   = smp_inc;
                    if (smp_inc == nsmp_q) begin
                        state_n   = S_DONE;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        cor_cen_n = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // An abort drops the core into reset so a partial LUT is never trusted
        if (abort_hit && (state == S_LOAD || state == S_FLUSH || state == S_RUN)) begin
            state_n     = S_DONE;
            cor_wen_n   = 1'b1;
            cor_cen_n   = 1'b1;
            cor_reset_n = 1'b0;
            smp_valid_n = 1'b0;
            done_n      = 1'b1;
            busy_n      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            ld_cnt     <= '0;
            fl_cnt     <= '0;
            smp_cnt    <= '0;
            nsmp_q     <= '0;
            fcw_q      <= '0;
            off_q      <= '0;
            rom_addr   <= '0;
            cor_index  <= '0;
            cor_d      <= '0;
            cor_fcw    <= '0;
            cor_offset <= '0;
            smp_data   <= '0;
            cor_reset  <= 1'b0;
            cor_cen    <= 1'b1;
            cor_wen    <= 1'b1;
            smp_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            ld_cnt     <= ld_cnt_n;
            fl_cnt     <= fl_cnt_n;
            smp_cnt    <= smp_cnt_n;
            nsmp_q     <= nsmp_q_n;
            fcw_q      <= fcw_q_n;
            off_q      <= off_q_n;
            rom_addr   <= rom_addr_n;
            cor_index  <= cor_index_n;
            cor_d      <= cor_d_n;
            cor_fcw    <= cor_fcw_n;
            cor_offset <= cor_offset_n;
            smp_data   <= smp_data_n;
            cor_reset  <= cor_reset_n;
            cor_cen    <= cor_cen_n;
            cor_wen    <= cor_wen_n;
            smp_valid  <= smp_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: random CORDIC valid/amp traffic against a per-transaction timeline model.
module tb_cordic_seq_ctrl;

    localparam int IDX_W   = 6;
    localparam int DW      = 48;
    localparam int AMP_W   = 16;
    localparam int RST_CYC = 4;
    localparam int CNT_W   = 16;
    localparam int LUT_N   = 64;
    localparam int FL0     = LUT_N + 2;      // cycle (after start) where the core reset goes low
    localparam int RUN0    = FL0 + RST_CYC;  // first cycle whose cor_wen_out can be captured
    localparam int LMAX    = 600;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [AMP_W-1:0] fcw_in, offset_in;
    logic [CNT_W-1:0] nsamples;
    logic [IDX_W-1:0] rom_addr;
    logic [DW-1:0]    rom_data;
    logic             cor_reset, cor_cen, cor_wen;
    logic [IDX_W-1:0] cor_index;
    logic [DW-1:0]    cor_d;
    logic [AMP_W-1:0] cor_fcw, cor_offset;
    logic             cor_wen_out;
    logic [AMP_W-1:0] cor_amp;
    logic             smp_valid;
    logic [AMP_W-1:0] smp_data;
    logic             busy, done;
`ifdef CORDIC_SEQ_ABORT_EN
    logic             abort;
`endif

    always #5 clk = ~clk;

    cordic_seq_ctrl #(
        .IDX_W(IDX_W), .DW(DW), .AMP_W(AMP_W), .RST_CYC(RST_CYC), .CNT_W(CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fcw_in     (fcw_in),
        .offset_in  (offset_in),
        .nsamples   (nsamples),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .cor_reset  (cor_reset),
        .cor_cen    (cor_cen),
        .cor_wen    (cor_wen),
        .cor_index  (cor_index),
        .cor_d      (cor_d),
        .cor_fcw    (cor_fcw),
        .cor_offset (cor_offset),
        .cor_wen_out(cor_wen_out),
        .cor_amp    (cor_amp),
`ifdef CORDIC_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .busy       (busy),
        .done       (done)
    );

    logic [DW-1:0] rom [LUT_N];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // State the model carries between transactions
    logic [AMP_W-1:0] prev_fcw, prev_off;
    logic             idle_rst;

    bit               wen_p  [LMAX];
    logic [AMP_W-1:0] amp_p  [LMAX];
    bit               exp_sv [LMAX];
    logic [AMP_W-1:0] exp_sd [LMAX];

    task automatic idle_cycles(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy",   64'(busy), 64'(0));
            chk("idle_done",   64'(done), 64'(0));
            chk("idle_wen",    64'(cor_wen), 64'(1));
            chk("idle_cen",    64'(cor_cen), 64'(1));
            chk("idle_smpv",   64'(smp_valid), 64'(0));
            chk("idle_rst",    64'(cor_reset), 64'(idle_rst));
            chk("idle_fcw",    64'(cor_fcw), 64'(prev_fcw));
            chk("idle_offset", 64'(cor_offset), 64'(prev_off));
            if (full) begin
                chk("rst_rom_addr", 64'(rom_addr), 64'(0));
                chk("rst_index",    64'(cor_index), 64'(0));
                chk("rst_d",        64'(cor_d), 64'(0));
                chk("rst_smp_data", 64'(smp_data), 64'(0));
            end
            start       = 1'b0;
            cor_wen_out = 1'($urandom_range(0, 1));
            cor_amp     = AMP_W'($urandom);
        end
    endtask

    // One start..done transaction. rst_at: cycle to pull reset (-1 none).
    // abort_k: -1 none, 0 abort during LOAD, k>0 abort once k samples are out.
    task automatic run_txn(input int ns, input logic [AMP_W-1:0] fcw, input logic [AMP_W-1:0] off,
                           input int wen_pct, input int rst_at, input int abort_k, input bit mid_start);
        int done_t, cnt, abort_at, end_t, exp_rst;
        bit loaded, wr;
        for (int t = 0; t < LMAX; t++) begin
            wen_p[t]  = ($urandom_range(1, 100) <= wen_pct) || (t >= RUN0 + 400);
            amp_p[t]  = AMP_W'($urandom);
            exp_sv[t] = 1'b0;
            exp_sd[t] = '0;
        end
        done_t   = (ns == 0) ? RUN0 : -1;
        cnt      = 0;
        abort_at = -1;
        if (ns > 0) begin
            for (int t = RUN0; t < LMAX - 1; t++) begin
                if (done_t < 0 && wen_p[t]) begin
                    cnt++;
                    exp_sv[t+1] = 1'b1;
                    exp_sd[t+1] = amp_p[t];
                    if (abort_k > 0 && cnt == abort_k) abort_at = t + 1;
                    if (cnt == ns) done_t = t + 1;
                end
            end
        end
        if (abort_k == 0) abort_at = 30;
        if (abort_at >= 0 && abort_at < done_t) begin
            done_t = abort_at + 1;
            for (int t = done_t; t < LMAX; t++) exp_sv[t] = 1'b0;
        end else begin
            abort_at = -1;
        end
        loaded = (done_t > FL0);
        end_t  = (rst_at >= 0) ? rst_at : done_t;

        start     = 1'b1;
        fcw_in    = fcw;
        offset_in = off;
        nsamples  = CNT_W'(ns);
`ifdef CORDIC_SEQ_ABORT_EN
        abort = (abort_k >= 0);
`endif
        for (int t = 0; t <= end_t; t++) begin
            @(negedge clk);
            wr = (t >= 2 && t <= FL0 - 1 && t < done_t);
            chk("busy",    64'(busy), 64'(t < done_t));
            chk("done",    64'(done), 64'(t == done_t));
            chk("cor_wen", 64'(cor_wen), 64'(!wr));
            if (wr) begin
                chk("cor_index", 64'(cor_index), 64'(t - 2));
                chk("cor_d",     64'(cor_d), 64'(rom[t-2]));
            end
            if (abort_at >= 0 && t >= done_t)  exp_rst = 0;
            else if (t >= FL0 && t < RUN0)     exp_rst = 0;
            else                               exp_rst = 1;
            chk("cor_reset", 64'(cor_reset), 64'(exp_rst));
            if (!(t >= FL0 && t < RUN0 && t < done_t))
                chk("cor_cen", 64'(cor_cen), 64'(t >= done_t));
            chk("cor_fcw",    64'(cor_fcw),    64'((t >= FL0 && loaded) ? fcw : prev_fcw));
            chk("cor_offset", 64'(cor_offset), 64'((t >= FL0 && loaded) ? off : prev_off));
            if (t <= FL0 - 1 && t < done_t)
                chk("rom_addr", 64'(rom_addr), 64'((t > 63) ? 63 : t));
            chk("smp_valid", 64'(smp_valid), 64'(exp_sv[t]));
            if (exp_sv[t]) chk("smp_data", 64'(smp_data), 64'(exp_sd[t]));

            start       = (mid_start && t == RUN0 + 1) || ($urandom_range(0, 19) == 0);
            fcw_in      = AMP_W'($urandom);
            offset_in   = AMP_W'($urandom);
            nsamples    = CNT_W'($urandom_range(0, 40));
            cor_wen_out = wen_p[t];
            cor_amp     = amp_p[t];
            reset       = (t != rst_at);
`ifdef CORDIC_SEQ_ABORT_EN
            abort = (t == abort_at);
`endif
        end

        if (rst_at >= 0) begin
            @(negedge clk);
            chk("rst_cor_reset", 64'(cor_reset), 64'(0));
            chk("rst_cor_cen",   64'(cor_cen), 64'(1));
            chk("rst_cor_wen",   64'(cor_wen), 64'(1));
            chk("rst_index",     64'(cor_index), 64'(0));
            chk("rst_d",         64'(cor_d), 64'(0));
            chk("rst_fcw",       64'(cor_fcw), 64'(0));
            chk("rst_offset",    64'(cor_offset), 64'(0));
            chk("rst_rom_addr",  64'(rom_addr), 64'(0));
            chk("rst_smpv",      64'(smp_valid), 64'(0));
            chk("rst_smp_data",  64'(smp_data), 64'(0));
            chk("rst_busy",      64'(busy), 64'(0));
            chk("rst_done",      64'(done), 64'(0));
            prev_fcw = '0;
            prev_off = '0;
            idle_rst = 1'b0;
            reset    = 1'b1;
        end else begin
            if (loaded) begin
                prev_fcw = fcw;
                prev_off = off;
            end
            idle_rst = (abort_at < 0);
        end
        start = 1'b0;
`ifdef CORDIC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        for (int k = 0; k < LUT_N; k++) rom[k] = {32'($urandom), 16'(k << 4)};
        reset       = 1'b0;
        start       = 1'b0;
        fcw_in      = '0;
        offset_in   = '0;
        nsamples    = '0;
        cor_wen_out = 1'b0;
        cor_amp     = '0;
`ifdef CORDIC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        prev_fcw = '0;
        prev_off = '0;
        idle_rst = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle_cycles(100, 1'b1);

        run_txn(16, 16'h0111, 16'h0020, 60, -1, -1, 1'b0);
        idle_cycles(4, 1'b0);
        run_txn(3, 16'h0222, 16'h0000, 100, -1, -1, 1'b1);
        idle_cycles(4, 1'b0);
        run_txn(0, 16'h0333, 16'h0005, 50, -1, -1, 1'b0);
        idle_cycles(4, 1'b0);
        run_txn(10, 16'h0444, 16'h0006, 50, 22, -1, 1'b0);
        idle_cycles(3, 1'b1);
        run_txn(5, 16'h0555, 16'h0007, 70, -1, -1, 1'b0);
        idle_cycles(3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_txn($urandom_range(0, 20), AMP_W'($urandom), AMP_W'($urandom),
                    $urandom_range(30, 100), -1, -1, 1'b0);
            idle_cycles($urandom_range(1, 5), 1'b0);
        end
`ifdef CORDIC_SEQ_ABORT_EN
        run_txn(12, 16'h0666, 16'h0008, 70, -1, 5, 1'b0);
        idle_cycles(3, 1'b0);
        run_txn(12, 16'h0777, 16'h0009, 70, -1, 0, 1'b0);
        idle_cycles(3, 1'b0);
        run_txn(4, 16'h0888, 16'h000a, 70, -1, -1, 1'b0);
        idle_cycles(3, 1'b0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit exceeded");
    end

endmodule

// File: doc/cordic_seq_ctrl.md
Name: cordic_seq_ctrl

Overview:
Sequencer for the CORDIC_16_pipe sine generator. On a start request it streams the 64-entry, 48-bit coefficient LUT from a synchronous ROM into the CORDIC write port, then pulses the CORDIC reset to flush the pipeline. It then runs the CORDIC with latched fcw/offset and forwards a programmed number of valid amplitude samples downstream. It sits between the top-level control/ROM and the CORDIC core, replacing hand-sequenced bench stimulus.

Parameters:
IDX_W, 6, LUT index width; LUT depth = 2**IDX_W
DW, 48, LUT word width
AMP_W, 16, CORDIC amplitude / fcw / offset width
RST_CYC, 4, cycles the CORDIC reset is held low in FLUSH (>=1)
CNT_W, 16, sample counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
fcw_in  in  AMP_W  frequency control word, latched at accepted start
offset_in  in  AMP_W  phase offset, latched at accepted start
nsamples  in  CNT_W  samples to capture, latched at accepted start
rom_addr  out  IDX_W  LUT ROM read address
rom_data  in  DW  ROM data, valid 1 cycle after rom_addr
cor_reset  out  1  CORDIC reset, active low
cor_cen  out  1  CORDIC chip enable, active low
cor_wen  out  1  CORDIC LUT write enable, active low
cor_index  out  IDX_W  CORDIC LUT write index
cor_d  out  DW  CORDIC LUT write data
cor_fcw  out  AMP_W  to CORDIC fcw
cor_offset  out  AMP_W  to CORDIC offset
cor_wen_out  in  1  CORDIC output-valid
cor_amp  in  AMP_W  CORDIC sin_amp
smp_valid  out  1  sample strobe
smp_data  out  AMP_W  sample value
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse on completion

Behaviour:
- All outputs registered. Reset values: cor_reset=0, cor_cen=1, cor_wen=1, cor_index=0, cor_d=0, cor_fcw=0, cor_offset=0, rom_addr=0, smp_valid=0, smp_data=0, busy=0, done=0; state IDLE; counters 0.
- States: IDLE -> LOAD -> FLUSH -> RUN -> DONE -> IDLE.
- IDLE: cor_cen=1, cor_wen=1, cor_reset holds last value. start=1 latches fcw_in/offset_in/nsamples, goes to LOAD. start outside IDLE is ignored (no queuing).
- LOAD: cor_reset=1, cor_cen=0. rom_addr steps 0..63, one per cycle. Each returned word is written with cor_index=k, cor_d=ROM[k], cor_wen=0 in the same cycle. Writes run in ascending order, exactly 64 consecutive cycles. The first write cycle is 2 clocks after the edge that sampled start. After the write of index 63, cor_wen=1 next cycle and the state moves to FLUSH. No index wrap or extra writes.
- FLUSH: cor_reset=0 for exactly RST_CYC cycles, cor_wen=1. cor_fcw/cor_offset take the latched values on FLUSH entry. Then cor_reset=1 and the state moves to RUN. If nsamples==0, FLUSH goes directly to DONE.
- RUN: cor_cen=0, cor_reset=1. Each cycle with cor_wen_out=1 registers cor_amp into smp_data with smp_valid=1 one cycle later, and increments the counter. When the counter reaches nsamples, the state moves to DONE. No samples are forwarded beyond nsamples, even if cor_wen_out stays high. cor_wen_out outside RUN is ignored.
- DONE: done=1 for one cycle, cor_cen=1, then IDLE. busy drops in the same cycle done is high. cor_fcw/cor_offset hold their values. cor_reset stays 1 so the core keeps its LUT.
- Counter arithmetic: unsigned, CNT_W bits. nsamples up to 2**CNT_W-1; no wrap.
- Reset asserted mid-operation: immediate return to reset values next edge. Any partial LUT load is discarded; a full reload occurs on the next start.

Optional Feature:
CORDIC_SEQ_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 in LOAD, FLUSH or RUN causes the following on the next edge:
  - cor_wen=1, cor_cen=1, cor_reset=0, smp_valid=0.
  - One-cycle done pulse, then IDLE.
  - abort is ignored in IDLE/DONE.
  - If abort and start are asserted together in IDLE, start wins.
- Undefined: the port does not exist and the sequence always runs to completion.

Test Plan:
- Reset low 2 cycles, then high, no start -> every output at its reset value, busy=0, no cor_wen activity for 100 cycles.
- ROM[k]=48'h000000_0000k0 style pattern, start with fcw=16'h0111, nsamples=16 -> cor_wen low exactly 64 consecutive cycles, cor_index 0..63 in order with matching cor_d, first write 2 cycles after start.
- Same run -> cor_reset low exactly RST_CYC=4 cycles after the last write, cor_fcw=16'h0111. Then exactly 16 smp_valid pulses, each equal to cor_amp of the prior cycle, one done pulse, busy=0.
- Model cor_wen_out held high continuously with nsamples=3 -> exactly 3 samples forwarded, done on the cycle after the 3rd sample is counted. Second start mid-RUN is ignored.
- nsamples=0 -> LOAD+FLUSH complete, no smp_valid, done pulse; reset asserted at LOAD write 20 -> all outputs at reset values next edge, next start reloads from index 0.
- With CORDIC_SEQ_ABORT_EN: abort during RUN after 5 samples -> smp_valid=0, cor_reset=0 next edge, single done pulse, IDLE.
